// File: rtl/uart_tx_fifo.sv
// Transmit FIFO with a drain FSM that feeds one byte at a time to UART_duplex.
// Optional sticky overflow flag is built when UART_TX_FIFO_OVF_EN is defined.
module uart_tx_fifo #(
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned START_TIMEOUT = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    uart_busy,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_send,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  input  logic                    ovf_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SEND       = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;
  logic                  full_q;
  logic                  empty_q;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  tx_send_q;
  logic [TW-1:0]         timer_q;
  logic                  push;
  logic                  pop;

  // A write while full is dropped even if a pop happens in the same cycle.
  assign push    = wr_en && !full_q;
  assign pop     = (state_q == IDLE) && !empty_q;
  assign count_d = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Drain FSM: pop, pulse tx_send, then wait for the UART busy/idle cycle.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      tx_data_q <= '0;
      tx_send_q <= 1'b0;
      timer_q   <= '0;
    end else begin
      tx_send_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!empty_q) begin
            tx_data_q <= mem_q[rd_ptr_q];
            tx_send_q <= 1'b1;
            state_q   <= SEND;
          end
        end
        SEND: begin
          timer_q <= '0;
          state_q <= WAIT_START;
        end
        WAIT_START: begin
          // Give up on a missed start pulse so the queue cannot deadlock.
          if (uart_busy) begin
            state_q <= WAIT_DONE;
          end else if (timer_q == TW'(START_TIMEOUT - 1)) begin
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        WAIT_DONE: begin
          if (!uart_busy) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data = tx_data_q;
  assign tx_send = tx_send_q;
  assign full    = full_q;
  assign empty   = empty_q;
  assign count   = count_q;

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_q;

  // Sticky dropped-write flag; a new drop wins over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      ovf_q <= 1'b0;
    end else if (wr_en && full_q) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign overflow = ovf_q;
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = ovf_clr;
  assign overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple UART busy model and byte scoreboard.
// Overflow expectations follow UART_TX_FIFO_OVF_EN.
module tb_uart_tx_fifo;

  localparam int DEPTH    = 8;
  localparam int BUSY_LEN = 20;
`ifdef UART_TX_FIFO_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       n_rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       uart_busy;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       overflow;
  logic       ovf_clr;

  uart_tx_fifo #(
    .DEPTH(8),
    .DATA_WIDTH(8),
    .START_TIMEOUT(4)
  ) u_dut (
    .clk(clk),
    .n_rst(n_rst),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .uart_busy(uart_busy),
    .tx_data(tx_data),
    .tx_send(tx_send),
    .full(full),
    .empty(empty),
    .count(count),
    .overflow(overflow),
    .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // UART model: 0 = normal (busy 1 cycle after tx_send, BUSY_LEN cycles), 1 = stuck high, 2 = stuck low
  int         busy_mode = 0;
  int         busy_cnt  = 0;
  bit         pend      = 1'b0;
  int         sends_n   = 0;
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (busy_mode == 1) begin
      uart_busy = 1'b1;
    end else if (busy_mode == 2) begin
      uart_busy = 1'b0;
      pend      = 1'b0;
      busy_cnt  = 0;
    end else if (pend) begin
      pend      = 1'b0;
      uart_busy = 1'b1;
      busy_cnt  = BUSY_LEN;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) uart_busy = 1'b0;
    end
    if (tx_send) begin
      sends_n++;
      if (exp_q.size() == 0) check("tx_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
      else check("tx_order", 32'(tx_data), 32'(exp_q.pop_front()));
      if (busy_mode == 0) begin
        check("send_while_busy", 32'(uart_busy | pend), 32'd0);
        pend = 1'b1;
      end
    end
  end

  // Occupancy scoreboard, stepped from the pushes driven and the pops seen on tx_send
  logic prev_wr  = 1'b0;
  logic prev_rst = 1'b0;
  int   exp_count = 0;

  always @(posedge clk) begin
    prev_wr  <= wr_en;
    prev_rst <= n_rst;
  end

  always @(negedge clk) begin
    if (!prev_rst) begin
      exp_count = 0;
    end else begin
      if (prev_wr && exp_count != DEPTH) exp_count++;
      if (tx_send) exp_count--;
    end
    check("count", 32'(count), 32'(exp_count));
    check("empty", 32'(empty), 32'(exp_count == 0));
    check("full", 32'(full), 32'(exp_count == DEPTH));
  end

  task automatic push(input logic [7:0] b, input bit accept);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = b;
    if (accept) exp_q.push_back(b);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      wr_en = 1'b0;
    end
  endtask

  task automatic wait_sends(input int target, input int budget, input string tag);
    int n = 0;
    while (sends_n < target && n < budget) begin
      @(negedge clk);
      wr_en = 1'b0;
      n++;
    end
    check(tag, 32'(sends_n), 32'(target));
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      wr_en = 1'b0;
      #1;
      n++;
    end while (uart_busy !== lvl && n < budget);
    check(tag, 32'(uart_busy), 32'(lvl));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    n_rst     = 1'b0;
    wr_en     = 1'b1;
    wr_data   = 8'h55;
    uart_busy = 1'b0;
    ovf_clr   = 1'b0;

    // 1: reset held with a write pending; nothing may be stored
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_count", 32'(count), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_send", 32'(tx_send), 32'd0);
    end
    check("rst_full", 32'(full), 32'd0);
    check("rst_txdata", 32'(tx_data), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    n_rst = 1'b1;
    wr_en = 1'b0;
    idle(3);
    check("rst_nothing_sent", 32'(sends_n), 32'd0);

    // 2: single byte, tx_send two cycles after the push edge
    s0 = sends_n;
    push(8'h41, 1'b1);
    @(negedge clk);
    wr_en = 1'b0;
    check("single_send_early", 32'(tx_send), 32'd0);
    check("single_count1", 32'(count), 32'd1);
    @(negedge clk);
    check("single_send", 32'(tx_send), 32'd1);
    check("single_data", 32'(tx_data), 32'h41);
    check("single_count0", 32'(count), 32'd0);
    idle(30);
    check("single_one_pulse", 32'(sends_n - s0), 32'd1);
    check("single_hold_data", 32'(tx_data), 32'h41);

    // 3: burst of 8 fills the FIFO while the UART is busy with a lead byte
    s0 = sends_n;
    push(8'h2F, 1'b1);
    wait_busy(1'b1, 10, "burst_lead_busy");
    for (int i = 0; i < 8; i++) push(8'(8'h30 + i), 1'b1);
    @(negedge clk);
    wr_en = 1'b0;
    check("burst_full", 32'(full), 32'd1);
    check("burst_count8", 32'(count), 32'd8);
    wait_sends(s0 + 9, 260, "burst_sends");
    idle(25);
    check("burst_empty", 32'(empty), 32'd1);

    // 4: overflow with the UART stuck busy
    s0 = sends_n;
    #1;
    busy_mode = 1;
    uart_busy = 1'b1;
    push(8'h80, 1'b1);
    idle(5);
    for (int i = 1; i <= 8; i++) push(8'(8'h80 + i), 1'b1);
    @(negedge clk);
    wr_en = 1'b0;
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_pre", 32'(overflow), 32'd0);
    push(8'h99, 1'b0);
    @(negedge clk);
    wr_en = 1'b0;
    check("ovf_drop_count", 32'(count), 32'd8);
    check("ovf_set", 32'(overflow), 32'(OVF_EXP));
    idle(3);
    check("ovf_sticky", 32'(overflow), 32'(OVF_EXP));
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = 8'h9A;
    ovf_clr = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
    ovf_clr = 1'b0;
    check("ovf_set_wins", 32'(overflow), 32'(OVF_EXP));
    check("ovf_drop2_count", 32'(count), 32'd8);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_cleared2", 32'(overflow), 32'd0);
    #1;
    busy_mode = 0;
    uart_busy = 1'b0;
    wait_sends(s0 + 9, 260, "ovf_drain_sends");
    idle(25);
    check("ovf_drain_empty", 32'(empty), 32'd1);

    // 5: UART never goes busy; start timeout releases the FSM
    #1;
    busy_mode = 2;
    uart_busy = 1'b0;
    push(8'hA5, 1'b1);
    push(8'hA6, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wr_en = 1'b0;
      check($sformatf("tmo_send_%0d", i), 32'(tx_send), 32'(i == 0 || i == 6));
      check($sformatf("tmo_data_%0d", i), 32'(tx_data), (i < 6) ? 32'hA5 : 32'hA6);
    end
    idle(10);
    check("tmo_empty", 32'(empty), 32'd1);

    // 6: pointer wrap with a push landing on a pop
    #1;
    busy_mode = 0;
    s0 = sends_n;
    for (int i = 0; i < 6; i++) push(8'(8'hB0 + i), 1'b1);
    wait_sends(s0 + 4, 120, "wrap_drain4");
    wait_busy(1'b1, 10, "wrap_busy_hi");
    wait_busy(1'b0, 30, "wrap_busy_lo");
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i), 1'b1);
    wait_sends(s0 + 11, 240, "wrap_sends");
    idle(25);
    check("wrap_empty", 32'(empty), 32'd1);
    check("wrap_all_out", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
